dpram_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that turns a dual-port RAM instance into a valid/ready streaming FIFO.
- Port A of the RAM is the write side. Port B is the read side, with a registered output that has 1-cycle latency and holds its value while the read enable is low.
- The block generates all RAM addresses and enables, and consumes RAM q_b into a 2-entry output stage, so the FIFO sustains one word per cycle.
- It sits between MSX-bus/producer logic and consumers such as the audio, video or SD streaming stages.

---
 rtl/dpram_fifo_ctrl.sv | 151 +++++++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl
// ---------------------------------------------------------------------------
// Single-clock FIFO controller that wraps an external dual-port RAM and
// presents it as a valid/ready streaming FIFO.
//
// Port summary
//   clk, reset_n       system clock, synchronous active-low reset
//   flush              synchronous clear of all FIFO state (RAM untouched)
//   in_data/in_valid/in_ready     producer side
//   out_data/out_valid/out_ready  consumer side
//   level              words held: RAM + in-flight read + output stage
//   ram_address_a, ram_data_a, ram_wren_a   RAM write port (port A)
//   ram_address_b, ram_rden_b, ram_q_b      RAM read port (port B),
//                                           q_b valid the cycle after rden_b
//
// Handshake: a word moves on a side only in a cycle where valid and ready
// are both high at the rising edge; valid never depends on ready, and the
// offered word holds steady until it is taken.
// ---------------------------------------------------------------------------
module dpram_fifo_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W+1:0] level,
    output logic [ADDR_W-1:0] ram_address_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_wren_a,
    output logic [ADDR_W-1:0] ram_address_b,
    output logic              ram_rden_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    // DEPTH expressed at mem_count width
    localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   mem_count;
    logic              rd_pending;
    logic              head_v;
    logic              skid_v;
    logic [DATA_W-1:0] head_d;
    logic [DATA_W-1:0] skid_d;

    logic              run_ok;
    logic              push;
    logic              pop;
    logic              issue;
    logic [1:0]        stage_cnt;
    logic [2:0]        occ_after;

    logic              head_v_n;
    logic              skid_v_n;
    logic [DATA_W-1:0] head_d_n;
    logic [DATA_W-1:0] skid_d_n;

    // Reset and flush both suppress any transfer in their cycle.
    assign run_ok = reset_n & ~flush;

    // in_ready looks only at registered state, so a slot freed by this
    // cycle's read is not rewritten until the next cycle: no same-edge
    // write/read to one address.
    assign in_ready = (mem_count < DEPTH_W);

    assign push = in_valid & in_ready & run_ok;
    assign pop  = head_v & out_ready & run_ok;

    assign stage_cnt = {1'b0, head_v} + {1'b0, skid_v};

    // Occupancy the output stage will see once this cycle's pop retires and
    // the pending read lands; a new read may only be issued if it still fits.
    assign occ_after = {1'b0, stage_cnt} + {2'b00, rd_pending} - {2'b00, pop};
    assign issue     = (mem_count != '0) & (occ_after < 3'd2) & run_ok;

    assign ram_wren_a    = push;
    assign ram_address_a = wr_ptr;
    assign ram_data_a    = in_data;
    assign ram_rden_b    = issue;
    assign ram_address_b = rd_ptr;

    assign out_valid = head_v;
    assign out_data  = head_d;

    assign level = {1'b0, mem_count}
                 + {{ADDR_W{1'b0}}, 1'b0, rd_pending}
                 + {{ADDR_W{1'b0}}, stage_cnt};

    // Output stage next state: the skid shifts into the head on pop first,
    // then the returning RAM word fills the first free entry.
    always_comb begin
        head_v_n = head_v;
        head_d_n = head_d;
        skid_v_n = skid_v;
        skid_d_n = skid_d;
        if (pop) begin
            head_v_n = skid_v;
            if (skid_v) begin
                head_d_n = skid_d;
            end
            skid_v_n = 1'b0;
        end
        if (rd_pending) begin
            if (!head_v_n) begin
                head_v_n = 1'b1;
                head_d_n = ram_q_b;
            end else begin
                skid_v_n = 1'b1;
                skid_d_n = ram_q_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            // Clearing rd_pending here drops any read already in flight, so
            // the q_b word that returns next cycle is never captured.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            rd_pending <= 1'b0;
            head_v     <= 1'b0;
            skid_v     <= 1'b0;
            head_d     <= '0;
            skid_d     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            mem_count  <= mem_count + {{ADDR_W{1'b0}}, push}
                                    - {{ADDR_W{1'b0}}, issue};
            rd_pending <= issue;
            head_v     <= head_v_n;
            head_d     <= head_d_n;
            skid_v     <= skid_v_n;
            skid_d     <= skid_d_n;
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl
// ---------------------------------------------------------------------------
// Directed bench for dpram_fifo_ctrl (ADDR_W=8, DATA_W=8) with a behavioural
// dual-port RAM. A per-cycle scoreboard tracks accepted words in exp_q and
// checks every popped word and head stability under backpressure.
// ---------------------------------------------------------------------------
module tb_dpram_fifo_ctrl;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] level;
    logic [7:0] ram_address_a;
    logic [7:0] ram_data_a;
    logic       ram_wren_a;
    logic [7:0] ram_address_b;
    logic       ram_rden_b;
    logic [7:0] ram_q_b;

    logic [7:0] mem [256];
    logic [7:0] exp_q[$];

    int total;
    int bad;
    int seg_push;
    int seg_pop;
    logic       hold_v;
    logic [7:0] hold_d;

    dpram_fifo_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .level         (level),
        .ram_address_a (ram_address_a),
        .ram_data_a    (ram_data_a),
        .ram_wren_a    (ram_wren_a),
        .ram_address_b (ram_address_b),
        .ram_rden_b    (ram_rden_b),
        .ram_q_b       (ram_q_b)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // behavioural RAM: registered port-B output that holds while rden is low
    always @(posedge clk) begin
        if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
        if (ram_rden_b) ram_q_b <= mem[ram_address_b];
    end

    // watchdog
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs were set at posedge+1; score at +2, then advance
    // to the next posedge+1.
    task automatic cycle();
        #1;
        if (!reset_n || flush) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_valid) chk("hold_data", {24'd0, out_data}, {24'd0, hold_d});
            if (out_valid && out_ready) begin
                seg_pop++;
                if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
                else chk("pop_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                seg_push++;
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (level == 10'd0 && exp_q.size() == 0) break;
            cycle();
        end
        #1;
        chk("drain_level", {22'd0, level}, 32'd0);
        chk("drain_queue", exp_q.size(), 32'd0);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        seg_push = 0;
        seg_pop  = 0;
        hold_v   = 1'b0;
        hold_d   = 8'd0;
        reset_n  = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h11;
        out_ready = 1'b0;

        // ---- reset held two cycles with in_valid high
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("reset_no_wren", {31'd0, ram_wren_a}, 32'd0);
            cycle();
        end
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", {24'd0, out_data}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_level", {22'd0, level}, 32'd0);

        // ---- single word 8'hA5
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        #1;
        chk("single_wren", {31'd0, ram_wren_a}, 32'd1);
        chk("single_addr_a", {24'd0, ram_address_a}, 32'd0);
        chk("single_data_a", {24'd0, ram_data_a}, 32'hA5);
        cycle();                                  // edge 0: write
        in_valid = 1'b0;
        #1;
        chk("single_rden", {31'd0, ram_rden_b}, 32'd1);
        chk("single_addr_b", {24'd0, ram_address_b}, 32'd0);
        chk("single_level_e0", {22'd0, level}, 32'd1);
        chk("single_ov_e0", {31'd0, out_valid}, 32'd0);
        cycle();                                  // edge 1: read issue
        #1;
        chk("single_ov_e1", {31'd0, out_valid}, 32'd0);
        chk("single_level_e1", {22'd0, level}, 32'd1);
        cycle();                                  // edge 2: capture
        #1;
        chk("single_ov_e2", {31'd0, out_valid}, 32'd1);
        chk("single_data_e2", {24'd0, out_data}, 32'hA5);
        cycle();                                  // edge 3: pop
        #1;
        chk("single_level_after", {22'd0, level}, 32'd0);
        chk("single_ov_after", {31'd0, out_valid}, 32'd0);

        // ---- streaming 0..299 (flush first to zero the pointers)
        flush = 1'b1;
        cycle();
        flush    = 1'b0;
        seg_pop  = 0;
        seg_push = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'(i);
            out_ready = 1'b1;
            #1;
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            chk("stream_addr_a", {24'd0, ram_address_a}, 32'(i % 256));
            cycle();
        end
        chk("stream_pushes", seg_push, 32'd300);
        chk("stream_pops", seg_pop, 32'd297);
        drain();

        // ---- full: out_ready low, push until in_ready drops
        seg_push  = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!in_ready) break;
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(0, 255));
            cycle();
        end
        in_valid = 1'b0;
        #1;
        chk("full_accepted", seg_push, 32'd258);
        chk("full_level", {22'd0, level}, 32'd258);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("full_pop_issue", {31'd0, ram_rden_b}, 32'd1);
        cycle();
        out_ready = 1'b0;
        #1;
        chk("full_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("full_level_after", {22'd0, level}, 32'd257);
        drain();

        // ---- backpressure: 1000 pushes, out_ready ~50%
        seg_push = 0;
        for (int k = 0; k < 5000; k++) begin
            if (seg_push >= 1000) break;
            in_valid  = 1'b1;
            in_data   = 8'($urandom_range(0, 255));
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        chk("bp_pushes", seg_push, 32'd1000);
        drain();

        // ---- flush mid-stream with a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hB0 + 8'(i);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();                                  // pop + read issue
        out_ready = 1'b0;
        #1;
        chk("flush_pre_level", {22'd0, level}, 32'd10);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        #1;
        chk("flush_no_wren", {31'd0, ram_wren_a}, 32'd0);
        chk("flush_no_rden", {31'd0, ram_rden_b}, 32'd0);
        cycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("flush_level", {22'd0, level}, 32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        cycle();
        #1;
        chk("flush_stale_ignored", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        cycle();                                  // edge N: push
        in_valid = 1'b0;
        cycle();                                  // edge N+1: issue
        cycle();                                  // edge N+2: capture
        #1;
        chk("flush_next_valid", {31'd0, out_valid}, 32'd1);
        chk("flush_next_data", {24'd0, out_data}, 32'h3C);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
